// File: rtl/fbfly_stage_i_if.sv
`default_nettype none
// ============================================================================
// Module   : fbfly_stage_i_if
// Brief    : Sample-stream bundle into and out of the DIF butterfly stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fbfly_stage_i_if #(
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18
);
    logic                      ien;
    logic [TOTAL_STAGE_P-1:0]  iaddr;
    logic [2*MULT_WIDTH_P-1:0] idata;
    logic                      oen;
    logic [TOTAL_STAGE_P-1:0]  oaddr;
    logic [2*MULT_WIDTH_P-1:0] odata;

    modport master (output ien, iaddr, idata, input  oen, oaddr, odata);
    modport slave  (input  ien, iaddr, idata, output oen, oaddr, odata);
endinterface
`default_nettype wire

// File: rtl/fbfly_stage_i.sv
`default_nettype none
// ============================================================================
// Module   : fbfly_stage_i
// Brief    : Radix-2 DIF butterfly: emits a+b inline, then drains a-b per group.
// Revision : 1.0 - initial release
// ============================================================================
module fbfly_stage_i #(
    parameter int FFT_STG       = 7,
    parameter int TOTAL_STAGE_P = 10,
    parameter int MULT_WIDTH_P  = 18,
    parameter int SCALE         = 1
) (
    input  wire logic       iclk,
    input  wire logic       irst_n,
    fbfly_stage_i_if.slave  bus
);
    localparam int W    = MULT_WIDTH_P;
    localparam int HALF = 2 ** (FFT_STG - 1);
    localparam int JW   = FFT_STG - 1;
    localparam int TW   = TOTAL_STAGE_P - FFT_STG;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COMB  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [JW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             dtag_q, dtag_d;
    logic                      s1_vld_q, s1_vld_d;
    logic [2*W-1:0]            s1_a_q, s1_a_d;
    logic [2*W-1:0]            s1_b_q, s1_b_d;
    logic [JW-1:0]             s1_j_q, s1_j_d;
    logic [TW-1:0]             s1_tag_q, s1_tag_d;
    logic                      oen_q, oen_d;
    logic [TOTAL_STAGE_P-1:0]  oaddr_q, oaddr_d;
    logic [2*W-1:0]            odata_q, odata_d;

    logic [2*W-1:0]            fb_mem [HALF];
    logic [2*W-1:0]            db_mem [HALF];

    logic [FFT_STG-1:0]        in_k;
    logic [JW-1:0]             in_j;
    logic [TW-1:0]             in_tag;
    logic                      in_first, in_sec, in_last;
    state_t                    in_state;
    logic                      drain_go, drain_end;
    logic [W:0]                a_re, a_im, b_re, b_im;
    logic [2*W-1:0]            sum_w, diff_w;

    assign in_k     = bus.iaddr[FFT_STG-1:0];
    assign in_j     = in_k[JW-1:0];
    assign in_tag   = bus.iaddr[TOTAL_STAGE_P-1:FFT_STG];
    assign in_first = bus.ien && !in_k[FFT_STG-1];
    assign in_sec   = bus.ien &&  in_k[FFT_STG-1];
    assign in_last  = bus.ien && (&in_k);
    // State an input alone would lead to when the stage is otherwise free.
    assign in_state = !in_sec ? ST_IDLE : (in_last ? ST_DRAIN : ST_COMB);

    // Scale by floor-halving, or keep full scale and clamp to the W-bit range.
    function automatic logic [W-1:0] fit(input logic [W:0] v);
        if (SCALE != 0)
            return v[W:1];
        else if (v[W] != v[W-1])
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return v[W-1:0];
    endfunction

    assign a_re   = {s1_a_q[2*W-1], s1_a_q[2*W-1:W]};
    assign a_im   = {s1_a_q[W-1],   s1_a_q[W-1:0]};
    assign b_re   = {s1_b_q[2*W-1], s1_b_q[2*W-1:W]};
    assign b_im   = {s1_b_q[W-1],   s1_b_q[W-1:0]};
    assign sum_w  = {fit(a_re + b_re), fit(a_im + b_im)};
    assign diff_w = {fit(a_re - b_re), fit(a_im - b_im)};

    // A pending sum owns the output port; the drain simply waits a cycle.
    assign drain_go  = (state_q == ST_DRAIN) && !s1_vld_q;
    assign drain_end = drain_go && (&idx_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dtag_d   = dtag_q;
        s1_vld_d = in_sec;
        s1_a_d   = fb_mem[in_j];
        s1_b_d   = bus.idata;
        s1_j_d   = in_j;
        s1_tag_d = in_tag;
        oen_d    = 1'b0;
        oaddr_d  = oaddr_q;
        odata_d  = odata_q;

        if (s1_vld_q) begin
            oen_d   = 1'b1;
            oaddr_d = {s1_tag_q, 1'b0, s1_j_q};
            odata_d = sum_w;
        end else if (drain_go) begin
            oen_d   = 1'b1;
            oaddr_d = {dtag_q, 1'b1, idx_q};
            odata_d = db_mem[idx_q];
            idx_d   = idx_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = in_state;
                if (in_last) dtag_d = in_tag;
            end
            ST_COMB: begin
                if (in_last) begin
                    state_d = ST_DRAIN;
                    dtag_d  = in_tag;
                end
            end
            ST_DRAIN: begin
                // The next frame's second half may begin on the last drain cycle.
                if (drain_end) begin
                    state_d = in_state;
                    if (in_last) dtag_d = in_tag;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dtag_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_j_q   <= '0;
            s1_tag_q <= '0;
            oen_q    <= 1'b0;
            oaddr_q  <= '0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dtag_q   <= dtag_d;
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_j_q   <= s1_j_d;
            s1_tag_q <= s1_tag_d;
            oen_q    <= oen_d;
            oaddr_q  <= oaddr_d;
            odata_q  <= odata_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (in_first) fb_mem[in_j]   <= bus.idata;
        if (s1_vld_q) db_mem[s1_j_q] <= diff_w;
    end

    assign bus.oen   = oen_q;
    assign bus.oaddr = oaddr_q;
    assign bus.odata = odata_q;
endmodule
`default_nettype wire

// File: tb/tb_fbfly_stage_i.sv
`default_nettype none
// ============================================================================
// Module   : tb_fbfly_stage_i
// Brief    : Directed bench for fbfly_stage_i, one SCALE=1 and one SCALE=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fbfly_stage_i;
    logic        iclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [9:0]  addr = '0;
    logic [35:0] data = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [45:0] exp_s1 [int];
    logic [45:0] exp_s0 [int];
    logic [45:0] log1 [$];
    logic [45:0] log0 [$];

    int          fb_re [4];
    int          fb_im [4];
    logic [35:0] db1 [4];
    logic [35:0] db0 [4];

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    fbfly_stage_i_if #(.TOTAL_STAGE_P(10), .MULT_WIDTH_P(18)) bus1 ();
    fbfly_stage_i_if #(.TOTAL_STAGE_P(10), .MULT_WIDTH_P(18)) bus0 ();
    assign bus1.ien = en;  assign bus1.iaddr = addr;  assign bus1.idata = data;
    assign bus0.ien = en;  assign bus0.iaddr = addr;  assign bus0.idata = data;

    fbfly_stage_i #(.FFT_STG(3), .TOTAL_STAGE_P(10), .MULT_WIDTH_P(18), .SCALE(1)) dut1 (
        .iclk(iclk), .irst_n(rst_n), .bus(bus1));
    fbfly_stage_i #(.FFT_STG(3), .TOTAL_STAGE_P(10), .MULT_WIDTH_P(18), .SCALE(0)) dut0 (
        .iclk(iclk), .irst_n(rst_n), .bus(bus0));

    function automatic logic [35:0] pk(input int re, input int im);
        logic [35:0] p;
        p[35:18] = re[17:0];
        p[17:0]  = im[17:0];
        return p;
    endfunction

    function automatic int fitm(input int v, input int s);
        if (s != 0) return v >>> 1;
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // Model: sums two cycles after the second-half input, diffs on the HALF
    // cycles following the last sum of a group.
    task automatic model_in(input logic [9:0] a, input logic [35:0] d);
        int k, j, tg, re, im;
        k  = int'(a[2:0]);
        tg = int'(a[9:3]);
        re = int'($signed(d[35:18]));
        im = int'($signed(d[17:0]));
        if (k < 4) begin
            fb_re[k] = re;
            fb_im[k] = im;
        end else begin
            j = k - 4;
            exp_s1[cyc+2] = {10'(tg*8 + j), pk(fitm(fb_re[j]+re, 1), fitm(fb_im[j]+im, 1))};
            exp_s0[cyc+2] = {10'(tg*8 + j), pk(fitm(fb_re[j]+re, 0), fitm(fb_im[j]+im, 0))};
            db1[j] = pk(fitm(fb_re[j]-re, 1), fitm(fb_im[j]-im, 1));
            db0[j] = pk(fitm(fb_re[j]-re, 0), fitm(fb_im[j]-im, 0));
            if (k == 7) begin
                for (int m = 0; m < 4; m++) begin
                    exp_s1[cyc+3+m] = {10'(tg*8 + 4 + m), db1[m]};
                    exp_s0[cyc+3+m] = {10'(tg*8 + 4 + m), db0[m]};
                end
            end
        end
    endtask

    task automatic chk_dut(input int s, input logic oe, input logic [9:0] oa, input logic [35:0] od);
        logic        v;
        logic [45:0] e;
        if (!rst_n) begin
            check($sformatf("rst_out_s%0d_c%0d", s, cyc), {17'd0, oe, oa, od}, 64'd0);
            return;
        end
        e = '0;
        v = 1'b0;
        if (s == 1) begin
            if (exp_s1.exists(cyc)) begin v = 1'b1; e = exp_s1[cyc]; exp_s1.delete(cyc); end
        end else begin
            if (exp_s0.exists(cyc)) begin v = 1'b1; e = exp_s0[cyc]; exp_s0.delete(cyc); end
        end
        check($sformatf("oen_s%0d_c%0d", s, cyc), {63'd0, oe}, {63'd0, v});
        if (v) check($sformatf("out_s%0d_c%0d", s, cyc), {18'd0, oa, od}, {18'd0, e});
        if (oe) begin
            if (s == 1) log1.push_back({oa, od});
            else        log0.push_back({oa, od});
        end
    endtask

    always @(negedge iclk) begin
        chk_dut(1, bus1.oen, bus1.oaddr, bus1.odata);
        chk_dut(0, bus0.oen, bus0.oaddr, bus0.odata);
    end

    task automatic step(input logic e, input logic [9:0] a, input logic [35:0] d);
        en = e; addr = a; data = d;
        if (e) model_in(a, d);
        @(posedge iclk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 36'd0);
    endtask

    task automatic frame(input int tg, input int gap, input int mre, input int mim);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 10'(tg*8 + k), pk(mre*k, mim*k));
            idle(gap);
        end
    endtask

    initial begin
        // Reset held with random input activity.
        repeat (8) begin
            @(posedge iclk); #1;
            en   = 1'($urandom);
            addr = 10'($urandom);
            data = {4'($urandom), 32'($urandom)};
        end
        en = 1'b0; addr = '0; data = '0;
        @(posedge iclk); #1;
        rst_n = 1'b1;
        idle(5);

        // Contiguous frame, tag 5.
        log1.delete(); log0.delete();
        frame(5, 0, 256, 0);
        idle(8);
        check("t2_count", 64'(log1.size()), 64'd8);
        check("t2_sum0",  64'(log1[0]), {18'd0, 10'd40, pk(512, 0)});
        check("t2_sum3",  64'(log1[3]), {18'd0, 10'd43, pk(1280, 0)});
        check("t2_diff0", 64'(log1[4]), {18'd0, 10'd44, pk(-512, 0)});
        check("t2_diff3", 64'(log1[7]), {18'd0, 10'd47, pk(-512, 0)});

        // Full-scale extremes in both scaling modes.
        log1.delete(); log0.delete();
        step(1'b1, 10'd24, pk(131071, -131072));
        for (int k = 1; k < 4; k++) step(1'b1, 10'(24 + k), 36'd0);
        step(1'b1, 10'd28, pk(1, -1));
        for (int k = 5; k < 8; k++) step(1'b1, 10'(24 + k), 36'd0);
        idle(8);
        check("t3_sat_sum",  64'(log0[0]), {18'd0, 10'd24, pk(131071, -131072)});
        check("t3_sat_diff", 64'(log0[4]), {18'd0, 10'd28, pk(131070, -131071)});
        check("t3_scl_sum",  64'(log1[0]), {18'd0, 10'd24, pk(65536, -65537)});
        check("t3_scl_diff", 64'(log1[4]), {18'd0, 10'd28, pk(65535, -65536)});

        // Gapped input: one valid every third cycle.
        frame(5, 2, 256, 0);
        idle(8);

        // Back-to-back frames.
        log1.delete(); log0.delete();
        frame(1, 0, 300, -50);
        frame(2, 0, -1000, 77);
        idle(10);
        check("t5_count", 64'(log0.size()), 64'd16);

        // Reset in the middle of a drain, after two diffs.
        log1.delete(); log0.delete();
        frame(6, 0, 128, 3);
        idle(3);
        #6;
        rst_n = 1'b0;
        exp_s1.delete(); exp_s0.delete();
        #1;
        check("t6_async_clear", {17'd0, bus1.oen, bus1.oaddr, bus1.odata}, 64'd0);
        check("t6_seen", 64'(log1.size()), 64'd6);
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        rst_n = 1'b1;
        frame(2, 0, 64, -9);
        idle(10);

        check("pending_s1", 64'(exp_s1.num()), 64'd0);
        check("pending_s0", 64'(exp_s0.num()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
